// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//   Execute-stage branch resolver. Compares each resolved control-flow
//   instruction against the prediction made for it at fetch. It produces a
//   registered front-end redirect and queues BTB training writes in a small
//   deduplicating FIFO. The FIFO drains one entry per cycle while the BTB
//   write port grants.
//
// Optional feature macro: BRU_PERF_CNT_EN
//   When defined, adds the perf_branches, perf_mispredicts and perf_drops
//   counters. Each is 32 bits wide, wraps, and is cleared by rst.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   ex_valid          EX holds a resolved control-flow instruction
//   ex_pc             PC of that instruction
//   ex_taken          actual direction
//   ex_target         actual taken target
//   ex_pred_hit       BTB hit recorded at fetch
//   ex_pred_target    BTB target recorded at fetch
//   redirect_valid    one-cycle pulse: fetch restarts at redirect_pc
//   redirect_pc       restart address (holds when redirect_valid=0)
//   btb_wr_valid      head entry available
//   btb_wr_pc         head entry PC (0 when empty)
//   btb_wr_target     head entry target (0 when empty)
//   btb_wr_ready      BTB write port accepts the head this cycle
//   fifo_full         queue occupancy == FIFO_DEPTH
//
// Handshake: the head entry transfers in any cycle where both btb_wr_valid
// and btb_wr_ready are high. btb_wr_valid never depends on btb_wr_ready.
// The head advances at that clock edge.
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
   parameter int FIFO_DEPTH = 4,
   parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_hit,
   input  logic [31:0] ex_pred_target,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        btb_wr_valid,
   output logic [31:0] btb_wr_pc,
   output logic [31:0] btb_wr_target,
   input  logic        btb_wr_ready,
   output logic        fifo_full
`ifdef BRU_PERF_CNT_EN
   ,
   output logic [31:0] perf_branches,
   output logic [31:0] perf_mispredicts,
   output logic [31:0] perf_drops
`endif
);

   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

   logic [31:0]      pc_mem  [FIFO_DEPTH];
   logic [31:0]      tgt_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] tail_ptr;
   logic [PTR_W:0]   count;

   logic target_wrong;
   logic mispredict;
   logic upd_req;
   logic is_empty;
   logic is_full;
   logic deq;
   logic dedup;
   logic enq;

   assign target_wrong = !ex_pred_hit || (ex_pred_target != ex_target);
   assign mispredict   = ex_valid && ((ex_taken && target_wrong) || (!ex_taken && ex_pred_hit));
   // Only taken outcomes train the BTB; there is no invalidate path.
   assign upd_req      = ex_valid && ex_taken && target_wrong;

   assign tail_ptr = wr_ptr - PTR_W'(1);
   assign is_empty = (count == '0);
   assign is_full  = (count == DEPTH_C);

   // The BTB must not see a write in the reset cycle, even when entries are queued.
   assign btb_wr_valid  = !is_empty && !rst;
   assign btb_wr_pc     = is_empty ? 32'd0 : pc_mem[rd_ptr];
   assign btb_wr_target = is_empty ? 32'd0 : tgt_mem[rd_ptr];
   assign fifo_full     = is_full;

   assign deq = btb_wr_valid && btb_wr_ready;

   // Rewrite the newest entry in place when it holds the same PC. The
   // exception is a sole entry that leaves this cycle; that request must
   // enqueue as a new entry instead.
   assign dedup = upd_req && !is_empty && (pc_mem[tail_ptr] == ex_pc) &&
                  !((count == (PTR_W+1)'(1)) && deq);

   // A dequeue in the same cycle frees a slot, so a full queue still accepts.
   assign enq = upd_req && !dedup && (!is_full || deq);

   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_valid <= 1'b0;
         redirect_pc    <= 32'd0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
      end else begin
         redirect_valid <= mispredict;
         if (mispredict) begin
            redirect_pc <= ex_taken ? ex_target : ex_pc + 32'd4;
         end
         if (deq) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (enq) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         case ({enq, deq})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: count gates every read of it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (enq) begin
            pc_mem[wr_ptr]  <= ex_pc;
            tgt_mem[wr_ptr] <= ex_target;
         end else if (dedup) begin
            tgt_mem[tail_ptr] <= ex_target;
         end
      end
   end

`ifdef BRU_PERF_CNT_EN
   logic drop;
   assign drop = upd_req && !dedup && is_full && !deq;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_branches    <= 32'd0;
         perf_mispredicts <= 32'd0;
         perf_drops       <= 32'd0;
      end else begin
         if (ex_valid) begin
            perf_branches <= perf_branches + 32'd1;
         end
         if (mispredict) begin
            perf_mispredicts <= perf_mispredicts + 32'd1;
         end
         if (drop) begin
            perf_drops <= perf_drops + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
//   Self-checking bench for branch_resolve_unit. The driver applies each
//   cycle's stimulus and advances a queue-based reference model. Expected
//   redirects, BTB writes and per-cycle status are pushed into scoreboard
//   queues, each tagged with the cycle in which it must appear. A negedge
//   monitor pops those entries and compares them whenever the DUT presents
//   output.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_valid = 1'b0;
   logic [31:0] ex_pc = '0;
   logic        ex_taken = 1'b0;
   logic [31:0] ex_target = '0;
   logic        ex_pred_hit = 1'b0;
   logic [31:0] ex_pred_target = '0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        btb_wr_valid;
   logic [31:0] btb_wr_pc;
   logic [31:0] btb_wr_target;
   logic        btb_wr_ready = 1'b0;
   logic        fifo_full;
`ifdef BRU_PERF_CNT_EN
   logic [31:0] perf_branches, perf_mispredicts, perf_drops;
`endif

   branch_resolve_unit #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
      .ex_pred_hit(ex_pred_hit), .ex_pred_target(ex_pred_target),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .btb_wr_valid(btb_wr_valid), .btb_wr_pc(btb_wr_pc), .btb_wr_target(btb_wr_target),
      .btb_wr_ready(btb_wr_ready), .fifo_full(fifo_full)
`ifdef BRU_PERF_CNT_EN
      , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts),
      .perf_drops(perf_drops)
`endif
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   typedef struct { logic [31:0] pc; logic [31:0] tgt; } ent_t;
   typedef struct { int cyc; logic [31:0] pc; logic [31:0] tgt; } wr_t;
   typedef struct { int cyc; logic [31:0] pc; } rd_t;
   typedef struct {
      int cyc; logic wv; logic full; logic [31:0] hpc; logic [31:0] htgt; logic [31:0] rpc;
   } st_t;

   ent_t m_q[$];          // reference model of the update queue
   wr_t  wr_exp_q[$];
   rd_t  rd_exp_q[$];
   st_t  st_exp_q[$];
   logic [31:0] m_rpc;
   logic [31:0] m_branches, m_mispredicts, m_drops;
   bit   known = 0;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // ---------------- driver + reference model ----------------
   task automatic drive(input logic r, input logic rdy, input logic v, input logic [31:0] pc,
                        input logic tk, input logic [31:0] tgt, input logic hit,
                        input logic [31:0] ptgt);
      st_t  s;
      logic deq, mp, up, ded;
      logic [31:0] npc;
      ent_t e;
      @(posedge clk);
      #1;
      rst = r; btb_wr_ready = rdy; ex_valid = v; ex_pc = pc; ex_taken = tk;
      ex_target = tgt; ex_pred_hit = hit; ex_pred_target = ptgt;
      deq = 1'b0;
      if (known) begin
         s.cyc  = cyc;
         s.wv   = !r && (m_q.size() != 0);
         s.full = (m_q.size() == DEPTH);
         s.hpc  = (m_q.size() != 0) ? m_q[0].pc  : 32'd0;
         s.htgt = (m_q.size() != 0) ? m_q[0].tgt : 32'd0;
         s.rpc  = m_rpc;
         st_exp_q.push_back(s);
         deq = s.wv && rdy;
      end
      if (r) begin
         m_q.delete();
         m_rpc = '0; m_branches = '0; m_mispredicts = '0; m_drops = '0;
         known = 1;
      end else if (known) begin
         mp  = v && ((tk && (!hit || ptgt != tgt)) || (!tk && hit));
         up  = v && tk && (!hit || ptgt != tgt);
         ded = up && (m_q.size() != 0) && (m_q[m_q.size()-1].pc == pc) &&
               !(m_q.size() == 1 && deq);
         if (deq) begin
            e = m_q.pop_front();
            wr_exp_q.push_back('{cyc, e.pc, e.tgt});
         end
         if (ded) m_q[m_q.size()-1].tgt = tgt;
         else if (up) begin
            if (m_q.size() == DEPTH) m_drops++;
            else m_q.push_back('{pc, tgt});
         end
         if (mp) begin
            npc = tk ? tgt : pc + 32'd4;
            rd_exp_q.push_back('{cyc + 1, npc});
            m_rpc = npc;
            m_mispredicts++;
         end
         if (v) m_branches++;
      end
   endtask

   task automatic idle(input logic rdy);
      drive(1'b0, rdy, 1'b0, '0, 1'b0, '0, 1'b0, '0);
   endtask

   task automatic cold(input logic rdy, input logic [31:0] pc, input logic [31:0] tgt);
      drive(1'b0, rdy, 1'b1, pc, 1'b1, tgt, 1'b0, '0);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      st_t s;
      rd_t rd;
      wr_t wr;
      if (st_exp_q.size() != 0 && st_exp_q[0].cyc == cyc) begin
         s = st_exp_q.pop_front();
         chk("btb_wr_valid", {31'd0, btb_wr_valid}, {31'd0, s.wv});
         chk("fifo_full", {31'd0, fifo_full}, {31'd0, s.full});
         chk("btb_wr_pc", btb_wr_pc, s.hpc);
         chk("btb_wr_target", btb_wr_target, s.htgt);
         chk("redirect_pc_hold", redirect_pc, s.rpc);
      end
      if (rd_exp_q.size() != 0 && rd_exp_q[0].cyc < cyc) begin
         rd = rd_exp_q.pop_front();
         chk("redirect_missing", 32'd0, 32'd1);
      end
      if (redirect_valid === 1'b1) begin
         if (rd_exp_q.size() != 0 && rd_exp_q[0].cyc == cyc) begin
            rd = rd_exp_q.pop_front();
            chk("redirect_pc", redirect_pc, rd.pc);
         end else begin
            chk("redirect_unexpected", 32'd1, 32'd0);
         end
      end
      if (wr_exp_q.size() != 0 && wr_exp_q[0].cyc < cyc) begin
         wr = wr_exp_q.pop_front();
         chk("btb_write_missing", 32'd0, 32'd1);
      end
      if (btb_wr_valid === 1'b1 && btb_wr_ready === 1'b1) begin
         if (wr_exp_q.size() != 0 && wr_exp_q[0].cyc == cyc) begin
            wr = wr_exp_q.pop_front();
            chk("btb_write_pc", btb_wr_pc, wr.pc);
            chk("btb_write_target", btb_wr_target, wr.tgt);
         end else begin
            chk("btb_write_unexpected", 32'd1, 32'd0);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);

      // reset while three entries are queued
      cold(1'b0, 32'hA0, 32'hA00);
      cold(1'b0, 32'hB0, 32'hB00);
      cold(1'b0, 32'hC0, 32'hC00);
      drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
      idle(1'b0);
      idle(1'b1);

      // cold taken branch
      cold(1'b1, 32'h100, 32'h200);
      idle(1'b1);
      idle(1'b1);

      // false hit on not-taken
      drive(1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 32'h400);
      idle(1'b1);
      idle(1'b1);

      // correct prediction
      drive(1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
      idle(1'b1);

      // full, drop, dedup
      cold(1'b0, 32'h10, 32'h1000);
      cold(1'b0, 32'h20, 32'h2000);
      cold(1'b0, 32'h30, 32'h3000);
      cold(1'b0, 32'h40, 32'h4000);
      idle(1'b0);
      cold(1'b0, 32'h50, 32'h5000);
      cold(1'b0, 32'h40, 32'h99);
      idle(1'b0);
`ifdef BRU_PERF_CNT_EN
      @(negedge clk);
      chk("perf_drops", perf_drops, m_drops);
`endif
      repeat (5) idle(1'b1);

      // simultaneous enqueue + dequeue on a full queue
      cold(1'b0, 32'h10, 32'h1100);
      cold(1'b0, 32'h20, 32'h2200);
      cold(1'b0, 32'h30, 32'h3300);
      cold(1'b0, 32'h40, 32'h4400);
      cold(1'b1, 32'h60, 32'h6600);
      repeat (6) idle(1'b1);

      // randomized traffic over a small PC/target space to provoke dedup and drops
      for (int i = 0; i < 400; i++) begin
         logic r, rdy, v, tk, hit;
         logic [31:0] pc, tgt, ptgt;
         r    = ($urandom_range(0, 79) == 0);
         rdy  = ($urandom_range(0, 9) < 4);
         v    = ($urandom_range(0, 9) < 7) && !r;
         pc   = 32'h1000 + 32'(4 * $urandom_range(0, 5));
         tk   = $urandom_range(0, 1);
         tgt  = 32'h2000 + 32'(4 * $urandom_range(0, 3));
         hit  = $urandom_range(0, 1);
         ptgt = 32'h2000 + 32'(4 * $urandom_range(0, 3));
         drive(r, rdy, v, pc, tk, tgt, hit, ptgt);
      end
      repeat (8) idle(1'b1);
      @(negedge clk);
      chk("redirect_queue_drained", rd_exp_q.size(), 32'd0);
      chk("write_queue_drained", wr_exp_q.size(), 32'd0);
`ifdef BRU_PERF_CNT_EN
      chk("perf_branches", perf_branches, m_branches);
      chk("perf_mispredicts", perf_mispredicts, m_mispredicts);
      chk("perf_drops_final", perf_drops, m_drops);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
